// File: rtl/poly_chord_player.sv
// Polyphonic note player: allocates notes to voices, ages them on beats, and
// mixes one sample per voice into a single codec sample on request.
module poly_chord_player #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned VIDX_W     = 2,
  parameter int unsigned NOTE_W     = 6,
  parameter int unsigned DUR_W      = 6,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play_enable,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [NOTE_W-1:0]              load_note,
  input  logic [DUR_W-1:0]               load_duration,
  input  logic                           beat,
  output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
  output logic [NUM_VOICES-1:0]          voice_active,
  output logic [NUM_VOICES-1:0]          voice_done,
  input  logic                           generate_next_sample,
  output logic                           voice_sample_req,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample_in,
  input  logic [NUM_VOICES-1:0]          voice_sample_valid,
  input  logic                           mix_mode,
  output logic signed [SAMPLE_W-1:0]     sample_out,
  output logic                           new_sample_ready
);

  localparam int unsigned SUM_W = SAMPLE_W + VIDX_W;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(VIDX_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(VIDX_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OUTPUT} state_e;

  logic [NOTE_W-1:0]          note_q   [NUM_VOICES];
  logic [DUR_W-1:0]           dur_q    [NUM_VOICES];
  logic [NUM_VOICES-1:0]      active_q, done_q;
  logic [VIDX_W-1:0]          load_sel;
  logic                       load_fire;

  state_e                     state_q, state_d;
  logic [NUM_VOICES-1:0]      pending_q, pending_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic signed [SAMPLE_W-1:0] sample_q [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] sample_d [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] out_q, out_d, mix_val;
  logic signed [SUM_W-1:0]    sum, shr;
  logic                       ready_q, ready_d, req_q, req_d;

  assign load_ready       = ~&active_q;
  assign load_fire        = load_valid & load_ready;
  assign voice_active     = active_q;
  assign voice_done       = done_q;
  assign voice_sample_req = req_q;
  assign sample_out       = out_q;
  assign new_sample_ready = ready_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
    assign voice_note[g*NOTE_W +: NOTE_W] = note_q[g];
  end

  // Lowest-index inactive voice receives the next note.
  always_comb begin
    load_sel = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!active_q[i]) load_sel = VIDX_W'(i);
    end
  end

  // Voice allocation and beat countdown; a load takes precedence over a beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= '0;
      done_q   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        dur_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (load_fire && load_sel == VIDX_W'(i)) begin
          note_q[i]   <= load_note;
          dur_q[i]    <= load_duration;
          active_q[i] <= (load_duration != '0);
          done_q[i]   <= (load_duration == '0);
        end else if (beat && play_enable && active_q[i]) begin
          dur_q[i] <= dur_q[i] - DUR_W'(1);
          if (dur_q[i] == DUR_W'(1)) begin
            active_q[i] <= 1'b0;
            done_q[i]   <= 1'b1;
          end
        end
      end
    end
  end

  // Widened signed sum of captured samples, then scale or clip.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      sum = sum + SUM_W'(sample_q[i]);
    end
    shr = sum >>> VIDX_W;
    if (!mix_mode)           mix_val = SAMPLE_W'(shr);
    else if (sum > SAT_MAX)  mix_val = SAMPLE_W'(SAT_MAX);
    else if (sum < SAT_MIN)  mix_val = SAMPLE_W'(SAT_MIN);
    else                     mix_val = SAMPLE_W'(sum);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      timer_q   <= '0;
      out_q     <= '0;
      ready_q   <= 1'b0;
      req_q     <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) sample_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      out_q     <= out_d;
      ready_q   <= ready_d;
      req_q     <= req_d;
      for (int i = 0; i < NUM_VOICES; i++) sample_q[i] <= sample_d[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    timer_d   = timer_q;
    out_d     = out_q;
    ready_d   = 1'b0;
    req_d     = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) sample_d[i] = sample_q[i];

    case (state_q)
      S_IDLE: begin
        if (generate_next_sample) begin
          // Cleared captures double as the zero sum and the timeout fill value.
          for (int i = 0; i < NUM_VOICES; i++) sample_d[i] = '0;
          timer_d = '0;
          if (play_enable && (active_q != '0)) begin
            pending_d = active_q;
            req_d     = 1'b1;
            state_d   = S_COLLECT;
          end else begin
            pending_d = '0;
            state_d   = S_OUTPUT;
          end
        end
      end
      S_COLLECT: begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (voice_sample_valid[i] && pending_q[i]) begin
            sample_d[i]  = voice_sample_in[i*SAMPLE_W +: SAMPLE_W];
            pending_d[i] = 1'b0;
          end
        end
        if (pending_d == '0 || timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = S_OUTPUT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_OUTPUT: begin
        out_d   = mix_val;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_poly_chord_player.sv
// Directed bench for poly_chord_player: voice allocation, beat ageing and mixing.
module tb_poly_chord_player;

  logic               clk = 1'b0;
  logic               reset;
  logic               play_enable, load_valid, load_ready, beat;
  logic [5:0]         load_note, load_duration;
  logic [17:0]        voice_note;
  logic [2:0]         voice_active, voice_done;
  logic               generate_next_sample, voice_sample_req;
  logic [47:0]        voice_sample_in;
  logic [2:0]         voice_sample_valid;
  logic               mix_mode;
  logic signed [15:0] sample_out;
  logic               new_sample_ready;

  int total = 0;
  int bad   = 0;

  poly_chord_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .load_valid           (load_valid),
    .load_ready           (load_ready),
    .load_note            (load_note),
    .load_duration        (load_duration),
    .beat                 (beat),
    .voice_note           (voice_note),
    .voice_active         (voice_active),
    .voice_done           (voice_done),
    .generate_next_sample (generate_next_sample),
    .voice_sample_req     (voice_sample_req),
    .voice_sample_in      (voice_sample_in),
    .voice_sample_valid   (voice_sample_valid),
    .mix_mode             (mix_mode),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  typedef struct {
    string      name;
    logic       mode;
    int         s0, s1, s2;
    logic [2:0] vmask;
    int         exp_out;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic load(input int note, input int dur);
    load_valid    = 1'b1;
    load_note     = 6'(note);
    load_duration = 6'(dur);
    tick();
    load_valid    = 1'b0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
    tick();
  endtask

  // One request; voices answer two cycles after the request is sampled.
  task automatic do_mix(input int s0, input int s1, input int s2, input logic [2:0] vm,
                        output int lat, output longint res, output int pulses);
    logic got;
    got = 1'b0;
    lat = 0;
    generate_next_sample = 1'b1;
    while (!got && lat < 400) begin
      tick();
      lat++;
      generate_next_sample = 1'b0;
      if (new_sample_ready) got = 1'b1;
      else if (lat == 2) begin
        voice_sample_in    = {16'(s2), 16'(s1), 16'(s0)};
        voice_sample_valid = vm;
      end else if (lat == 3) voice_sample_valid = '0;
    end
    voice_sample_valid = '0;
    if (!got) lat = -1;
    res    = longint'(sample_out);
    pulses = got ? 1 : 0;
    repeat (6) begin
      tick();
      if (new_sample_ready) pulses++;
    end
  endtask

  task automatic run_mix(input string name, input int s0, input int s1, input int s2,
                         input logic [2:0] vm, input int exp_out, input int exp_lat);
    int lat, pulses;
    longint res;
    do_mix(s0, s1, s2, vm, lat, res, pulses);
    chk({name, "_out"}, res, exp_out);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_pulses"}, pulses, 1);
    chk({name, "_hold"}, longint'(sample_out), exp_out);
  endtask

  initial begin
    logic [17:0] exp_notes;
    int ready_seen;

    vecs[0] = '{"avg3",     1'b0,   1000,   2000,   3000, 3'b111,   1500,   4};
    vecs[1] = '{"satpos",   1'b1,  20000,  20000,  20000, 3'b111,  32767,   4};
    vecs[2] = '{"satneg",   1'b1, -20000, -20000, -20000, 3'b111, -32768,   4};
    vecs[3] = '{"avgneg",   1'b0,  -1000,  -2000,  -3000, 3'b111,  -1500,   4};
    vecs[4] = '{"floorm1",  1'b0,     -1,      0,      0, 3'b111,     -1,   4};
    vecs[5] = '{"satin",    1'b1,    100,   -200,     50, 3'b111,    -50,   4};
    vecs[6] = '{"avgmax",   1'b0,  32767,  32767,  32767, 3'b111,  24575,   4};
    vecs[7] = '{"satmin",   1'b1, -32768, -32768, -32768, 3'b111, -32768,   4};
    vecs[8] = '{"timeout",  1'b0,   4000,   8000,  12345, 3'b011,   3000, 257};

    reset = 1'b0;
    play_enable = 1'b1;
    load_valid = 1'b0;
    load_note = '0;
    load_duration = '0;
    beat = 1'b0;
    generate_next_sample = 1'b0;
    voice_sample_in = '0;
    voice_sample_valid = '0;
    mix_mode = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    chk("rst_load_ready", load_ready, 1);
    chk("rst_active", voice_active, 0);
    chk("rst_done", voice_done, 0);
    chk("rst_note", voice_note, 0);
    chk("rst_sample_out", sample_out, 0);
    chk("rst_ready", new_sample_ready, 0);
    chk("rst_req", voice_sample_req, 0);

    load(7, 0);
    chk("zdur_active", voice_active, 0);
    chk("zdur_done", voice_done, 3'b001);
    chk("zdur_load_ready", load_ready, 1);

    load(10, 2);
    load(20, 2);
    load(30, 2);
    exp_notes = {6'd30, 6'd20, 6'd10};
    chk("l3_active", voice_active, 3'b111);
    chk("l3_load_ready", load_ready, 0);
    chk("l3_notes", voice_note, exp_notes);
    chk("l3_done", voice_done, 0);
    pulse_beat();
    chk("b1_active", voice_active, 3'b111);
    pulse_beat();
    chk("b2_active", voice_active, 0);
    chk("b2_done", voice_done, 3'b111);

    beat = 1'b1;
    load(5, 1);
    beat = 1'b0;
    chk("same_beat_active", voice_active, 3'b001);
    chk("same_beat_done", voice_done, 3'b110);
    pulse_beat();
    chk("same_beat_end_active", voice_active, 0);
    chk("same_beat_end_done", voice_done, 3'b111);

    load(11, 5);
    load(12, 5);
    load(13, 5);
    chk("mix_setup_active", voice_active, 3'b111);
    for (int i = 0; i < 9; i++) begin
      mix_mode = vecs[i].mode;
      run_mix(vecs[i].name, vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].vmask,
              vecs[i].exp_out, vecs[i].exp_lat);
    end
    chk("mix_active_kept", voice_active, 3'b111);

    play_enable = 1'b0;
    repeat (5) pulse_beat();
    chk("frozen_active", voice_active, 3'b111);
    run_mix("silent", 5000, 5000, 5000, 3'b111, 0, 2);
    play_enable = 1'b1;
    repeat (4) pulse_beat();
    chk("thaw4_active", voice_active, 3'b111);
    pulse_beat();
    chk("thaw5_active", voice_active, 0);
    chk("thaw5_done", voice_done, 3'b111);

    load(1, 5);
    load(2, 5);
    load(3, 5);
    mix_mode = 1'b0;
    run_mix("pre_rst", 400, 400, 400, 3'b111, 300, 4);
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_sample_out", sample_out, 0);
    chk("mid_rst_active", voice_active, 0);
    chk("mid_rst_done", voice_done, 0);
    chk("mid_rst_note", voice_note, 0);
    chk("mid_rst_req", voice_sample_req, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    ready_seen = 0;
    repeat (10) begin
      tick();
      if (new_sample_ready) ready_seen++;
    end
    chk("mid_rst_no_pulse", ready_seen, 0);
    chk("mid_rst_load_ready", load_ready, 1);
    load(1, 5);
    load(2, 5);
    chk("post_rst_active", voice_active, 3'b011);
    run_mix("post_rst", 1000, 2000, 30000, 3'b111, 750, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
